// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_grant_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       preempt;
  modport master (output req, input grant, grant_id, grant_valid, preempt);
  modport slave  (input req, output grant, grant_id, grant_valid, preempt);
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 8-way round-robin arbiter with registered grant and hold limit
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input logic            clk,
  input logic            rst,
  rr_grant_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t              state_q, state_d;
  logic [2:0]          id_q, id_d, last_q, last_d, pos, win;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                pre_q, pre_d, at_lim;
  logic [15:0]         dbl;
  logic [7:0]          rot;
  // rotate req so last-1 sits at bit 7 and last at bit 0, then take the highest set bit
  always_comb begin
    dbl = {bus.req, bus.req} >> last_q;
    rot = dbl[7:0];
    pos = 3'd0;
    for (int i = 0; i < 8; i++) if (rot[i]) pos = 3'(i);
    win = pos + last_q;
  end
  assign at_lim = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));
  // next state: arbitrate when idle, on release, or at the hold limit; otherwise keep holding
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    if (state_q == IDLE || !bus.req[id_q] || at_lim) begin
      state_d = (bus.req != 8'd0) ? GRANT : IDLE;
      id_d    = (bus.req != 8'd0) ? win : 3'd0;
      last_d  = (bus.req != 8'd0) ? win : last_q;
      hold_d  = '0;
      pre_d   = (state_q == GRANT) && bus.req[id_q] && (win != id_q);
    end else hold_d = hold_q + HOLD_W'(hold_q != '1);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      last_q  <= 3'd0;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end
  assign bus.grant       = (state_q == GRANT) ? (8'b1 << id_q) : 8'b0;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.preempt     = pre_q;
endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Selection uses the team's highest-index-first priority encoding over a rotated request vector, so arbitration is fair over time.
- Grants are registered and held while the owner keeps its request asserted, up to a programmable hold limit.
- Sits in front of any shared datapath port; downstream logic steers with grant_id.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the limit.
- HOLD_W, 5, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  per-requester request; a requester holds its bit high until done.
- grant  output  8  one-hot grant, all-zero when idle.
- grant_id  output  3  index of the granted requester; 0 when idle.
- grant_valid  output  1  high when a grant is active (equals OR of grant).
- preempt  output  1  one-cycle pulse when the hold limit forces a grant away from a still-requesting owner.

Behaviour:
- All outputs are registered. No combinational path from req to any output.
- Reset (rst=1 at a clock edge):
  - grant=0, grant_id=0, grant_valid=0, preempt=0.
  - state=IDLE, hold_cnt=0, last=0.
  - Reset overrides everything, including mid-grant; the grant drops the cycle after rst is sampled.
- Priority order: descending rotation from last.
  - Order is last-1, last-2, ..., 0, 7, ..., last (last is lowest).
  - With last=0 after reset the order is 7,6,...,0, identical to fixed highest-index priority.
- States:
  - IDLE: grant=0. If req!=0 at an edge, register winner w, go to GRANT with hold_cnt=0 and last=w. Latency is 1 cycle from req sampled to grant visible.
  - GRANT: owner o=grant_id.
    - If req[o]=0 (release): re-arbitrate over req in the same edge. If any request remains, grant the new winner next cycle (back-to-back, no idle bubble), hold_cnt=0, last=winner. Otherwise go to IDLE with grant=0.
    - If req[o]=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (limit): re-arbitrate with o lowest priority.
      - If another request exists, switch to it and pulse preempt=1 for exactly the first cycle of the new grant.
      - If o is the sole requester, re-grant o with hold_cnt=0 and preempt=0.
    - Otherwise hold the grant and increment hold_cnt.
- Maximum grant length is MAX_HOLD consecutive cycles. hold_cnt never exceeds MAX_HOLD-1 and does not wrap when MAX_HOLD=0; it saturates.
- Simultaneous requests are resolved only by the rotated order. A new requester arriving during a grant waits for release or the limit.
- A requester whose bit drops without being granted is simply not considered. No request is queued.
- grant stays one-hot or zero at all times, and grant_id is always consistent with grant.

Test Plan:
- Reset priority: after reset, req=8'b1000_0001 held → cycle+1 grant=8'h80, grant_id=7, grant_valid=1. Release req[7] → next cycle grant=8'h01, grant_id=0, no idle cycle in between.
- Rotation fairness: req=8'hFF held, each owner releases after 1 cycle and re-asserts → grant_id sequence 7,6,5,4,3,2,1,0,7.
- Hold limit: MAX_HOLD=16, req=8'b0000_0110 with both held → grant_id=2 for exactly 16 cycles, then grant_id=1 with preempt=1 for one cycle. After 16 more cycles, grant_id=2 with preempt=1.
- Sole requester at limit: only req[4] held 40 cycles → grant_id=4 continuous, grant_valid=1 continuous, preempt never asserted.
- Idle and reset mid-grant:
  - req 0→8'h08 for 3 cycles then 0 → grant=8'h08 for cycles 1-3, then 0.
  - Assert rst during a grant → all outputs 0 the next cycle, and the next arbitration uses order 7..0.
- MAX_HOLD=0: two requesters held 100 cycles → first winner keeps the grant for all 100 cycles, with no preempt.
